// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------
// uart_pkg : shared types, constants and helpers for the UART blocks
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int MAJ_TAPS  = 3;

  function automatic bit params_legal(input longint clk_hz, input longint baud,
                                      input longint oversample, input longint acc_w);
    return (oversample % 2 == 0) && (oversample >= 8) && (acc_w > 0) && (acc_w < 63) &&
           ((clk_hz + baud * oversample) < (longint'(1) << acc_w));
  endfunction

  function automatic logic majority(input logic [MAJ_TAPS-1:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < MAJ_TAPS; i++) begin
      ones += int'(v[i]);
    end
    return (ones > MAJ_TAPS / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------
// uart_baud_tick : fractional phase-accumulator oversample tick generator
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_baud_tick #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 1_500_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam logic [ACC_W-1:0] INC   = ACC_W'(longint'(BAUD) * longint'(OVERSAMPLE));
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(longint'(CLK_HZ));

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  assign sum = acc + INC;

  // Free-running: the remainder carries over so long-term rate is exact.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= LIMIT) begin
      acc  <= sum - LIMIT;
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------
// uart_rx_deserializer : 8N1 LSB-first receiver with majority-vote oversampling
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 1_500_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rxReady,
  output logic [7:0] rxData,
  output logic       frameErr,
  output logic       rxBusy
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLE / 2);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  if (!params_legal(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE), longint'(ACC_W)))
  begin : g_bad_params
    $error("uart_rx_deserializer: illegal CLK_HZ/BAUD/OVERSAMPLE/ACC_W combination");
  end

  logic                  tick;
  logic                  sync1;
  logic                  sync2;
  logic                  rxs;
  logic [MAJ_TAPS-2:0]   samp;
  logic                  vote;
  rx_state_t             state;
  logic [TCW-1:0]        tcnt;
  logic [BCW-1:0]        bitcnt;
  logic [DATA_BITS-1:0]  shreg;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .ACC_W      (ACC_W)
  ) u_baud_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
    end
  end

  assign rxs    = sync2;
  // Vote over the two previous ticks plus the one being evaluated now.
  assign vote   = majority({samp, rxs});
  assign rxBusy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tcnt     <= '0;
      bitcnt   <= '0;
      samp     <= '0;
      shreg    <= '0;
      rxData   <= 8'h00;
      rxReady  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      rxReady  <= 1'b0;
      frameErr <= 1'b0;
      if (tick) begin
        samp <= {samp[MAJ_TAPS-3:0], rxs};
      end
      case (state)
        IDLE: begin
          tcnt   <= '0;
          bitcnt <= '0;
          if (!rxs) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt == TICK_MID && vote) begin
              state <= IDLE;
              tcnt  <= '0;
            end else if (tcnt == TICK_LAST) begin
              state  <= DATA;
              tcnt   <= '0;
              bitcnt <= '0;
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt == TICK_MID) begin
              shreg[bitcnt] <= vote;
            end
            if (tcnt == TICK_LAST) begin
              tcnt <= '0;
              if (bitcnt == BIT_LAST) begin
                state <= STOP;
              end else begin
                bitcnt <= bitcnt + BCW'(1);
              end
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
        end
        STOP: begin
          // Decide at mid-bit so a start bit immediately following is not missed.
          if (tick) begin
            if (tcnt == TICK_MID) begin
              tcnt <= '0;
              if (vote) begin
                rxData  <= shreg;
                rxReady <= 1'b1;
                state   <= IDLE;
              end else begin
                frameErr <= 1'b1;
                state    <= WAIT_IDLE;
              end
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
        end
        WAIT_IDLE: begin
          if (tick && rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------
// tb_uart_rx_deserializer : directed self-checking bench for the UART receiver
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

  localparam real BIT_NS = 160.0;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   = 1'b1;
  logic       rxReady;
  logic [7:0] rxData;
  logic       frameErr;
  logic       rxBusy;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int ready_cnt = 0;
  int err_cnt   = 0;
  int busy_cnt  = 0;
  int proto_viol = 0;
  int ready_cyc = 0;
  int fall_cyc  = 0;
  logic [7:0] got[$];
  logic prev_ready = 1'b0;
  logic prev_err   = 1'b0;

  uart_rx_deserializer #(
    .CLK_HZ     (16_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (16),
    .ACC_W      (32)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .rxReady  (rxReady),
    .rxData   (rxData),
    .frameErr (frameErr),
    .rxBusy   (rxBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxReady) begin
      ready_cnt++;
      ready_cyc = cyc;
      got.push_back(rxData);
    end
    if (frameErr) err_cnt++;
    if (rxBusy) busy_cnt++;
    if ((rxReady && frameErr) || ((rxReady || frameErr) && (prev_ready || prev_err)))
      proto_viol++;
    prev_ready = rxReady;
    prev_err   = frameErr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
    fall_cyc = cyc;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  initial begin
    int r0, e0, b0, n0, lat;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", rxReady, 1'b0);
    check("rst_err", frameErr, 1'b0);
    check("rst_data", rxData, 8'h00);
    check("rst_busy", rxBusy, 1'b0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA5 with latency
    r0 = ready_cnt; e0 = err_cnt;
    @(negedge clk);
    send_byte(8'hA5, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    lat = ready_cyc - fall_cyc - 1;
    check("a5_count", ready_cnt - r0, 1);
    check("a5_data", rxData, 8'hA5);
    check("a5_last", got[got.size()-1], 8'hA5);
    check("a5_noerr", err_cnt - e0, 0);
    check("a5_latency_ok", (lat >= 153 && lat <= 155), 1'b1);

    // Back-to-back 0x00, 0xFF, 0x31
    r0 = ready_cnt; n0 = got.size();
    @(negedge clk);
    send_byte(8'h00, BIT_NS, 1'b1);
    send_byte(8'hFF, BIT_NS, 1'b1);
    send_byte(8'h31, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_count", ready_cnt - r0, 3);
    check("b2b_d0", got[n0], 8'h00);
    check("b2b_d1", got[n0+1], 8'hFF);
    check("b2b_d2", got[n0+2], 8'h31);

    // 5-clk glitch on idle line
    r0 = ready_cnt; e0 = err_cnt; b0 = busy_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_ready", ready_cnt - r0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy_le9", ((busy_cnt - b0) >= 1 && (busy_cnt - b0) <= 9), 1'b1);
    check("glitch_idle", rxBusy, 1'b0);

    // 0x5A with low stop bit followed by a break
    r0 = ready_cnt; e0 = err_cnt;
    @(negedge clk);
    send_byte(8'h5A, BIT_NS, 1'b0);
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("brk_err_once", err_cnt - e0, 1);
    check("brk_noready", ready_cnt - r0, 0);
    check("brk_data_held", rxData, 8'h31);
    check("brk_idle", rxBusy, 1'b0);
    send_byte(8'h12, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    check("post_brk_count", ready_cnt - r0, 1);
    check("post_brk_data", rxData, 8'h12);
    check("post_brk_err", err_cnt - e0, 1);

    // Reset pulse in the middle of data bit 4 of 0x3C
    r0 = ready_cnt; e0 = err_cnt;
    @(negedge clk);
    fork
      send_byte(8'h3C, BIT_NS, 1'b1);
      begin
        repeat (87) @(negedge clk);
        check("mid_busy", rxBusy, 1'b1);
        rstn = 1'b0;
        #1;
        check("arst_ready", rxReady, 1'b0);
        check("arst_err", frameErr, 1'b0);
        check("arst_data", rxData, 8'h00);
        check("arst_busy", rxBusy, 1'b0);
      end
    join
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_discard", ready_cnt - r0, 0);
    check("arst_noerr", err_cnt - e0, 0);
    send_byte(8'h77, BIT_NS, 1'b1);
    repeat (4) @(negedge clk);
    check("post_rst_count", ready_cnt - r0, 1);
    check("post_rst_data", rxData, 8'h77);

    // Sender clock +3% then -3%
    r0 = ready_cnt;
    send_byte(8'hC3, BIT_NS / 1.03, 1'b1);
    repeat (6) @(negedge clk);
    check("fast_count", ready_cnt - r0, 1);
    check("fast_data", rxData, 8'hC3);
    r0 = ready_cnt; e0 = err_cnt;
    send_byte(8'hC3, BIT_NS / 0.97, 1'b1);
    repeat (6) @(negedge clk);
    check("slow_count", ready_cnt - r0, 1);
    check("slow_data", rxData, 8'hC3);
    check("slow_noerr", err_cnt - e0, 0);

    check("pulse_protocol", proto_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
